// File: rtl/mdu_hilo.sv
// mdu_hilo: multiply/divide-unit front end.
// It launches MULT/MULTU on an external sequential multiplier and captures the
// 64-bit product into HI/LO after a fixed number of RUN cycles. It also serves
// MFHI/MFLO/MTHI/MTLO. op_ready stays low while a multiply is in flight, so a
// HI/LO read that follows a multiply always returns the new product.
module mdu_hilo #(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               op_ready,
  output logic               rd_valid,
  output logic [WIDTH-1:0]   rd_data,
  output logic               busy,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               mul_start,
  output logic               mul_is_signed,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_y
);

  localparam int CW = $clog2(MUL_LATENCY + 1);
  // Counter value seen during the final RUN cycle; the counter is cleared on
  // acceptance, so the first RUN cycle sees 0.
  localparam logic [CW-1:0] LAST_COUNT = CW'(MUL_LATENCY - 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_MFHI  = 3'd2;
  localparam logic [2:0] OP_MFLO  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic              rdValid_q;
  logic [WIDTH-1:0]  rdData_q;
  logic [WIDTH-1:0]  hi_q;
  logic [WIDTH-1:0]  lo_q;
  logic              mulStart_q;
  logic              mulSigned_q;
  logic [WIDTH-1:0]  mulA_q;
  logic [WIDTH-1:0]  mulB_q;

  // Next count value while the multiplier is running.
  always_comb begin
    count_d = count_q + CW'(1);
  end

  // Whole FSM: acceptance, HI/LO moves, multiplier launch and product capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rdValid_q   <= 1'b0;
      rdData_q    <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      mulStart_q  <= 1'b0;
      mulSigned_q <= 1'b0;
      mulA_q      <= '0;
      mulB_q      <= '0;
    end else begin
      rdValid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (op_valid) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                mulA_q      <= op_a;
                mulB_q      <= op_b;
                mulSigned_q <= (op == OP_MULT);
                mulStart_q  <= 1'b1;
                count_q     <= '0;
                state_q     <= RUN;
              end
              OP_MFHI: begin
                rdData_q  <= hi_q;
                rdValid_q <= 1'b1;
              end
              OP_MFLO: begin
                rdData_q  <= lo_q;
                rdValid_q <= 1'b1;
              end
              OP_MTHI: hi_q <= op_a;
              OP_MTLO: lo_q <= op_a;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (count_q == LAST_COUNT) begin
            hi_q       <= mul_y[2*WIDTH-1:WIDTH];
            lo_q       <= mul_y[WIDTH-1:0];
            mulStart_q <= 1'b0;
            count_q    <= '0;
            state_q    <= IDLE;
          end else begin
            count_q <= count_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign op_ready      = (state_q == IDLE);
  assign busy          = (state_q == RUN);
  assign rd_valid      = rdValid_q;
  assign rd_data       = rdData_q;
  assign hi            = hi_q;
  assign lo            = lo_q;
  assign mul_start     = mulStart_q;
  assign mul_is_signed = mulSigned_q;
  assign mul_a         = mulA_q;
  assign mul_b         = mulB_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed bench for mdu_hilo at the default latency (32) and at
// latency 1, each paired with a behavioural multiplier that only presents a
// valid product during the last cycle of continuous start.
module tb_mdu_hilo;

  localparam logic [2:0] MULT  = 3'd0;
  localparam logic [2:0] MULTU = 3'd1;
  localparam logic [2:0] MFHI  = 3'd2;
  localparam logic [2:0] MFLO  = 3'd3;
  localparam logic [2:0] MTHI  = 3'd4;
  localparam logic [2:0] MTLO  = 3'd5;
  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

  logic        clk;
  logic        rst;

  logic        opValid;
  logic [2:0]  op;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        opReady;
  logic        rdValid;
  logic [31:0] rdData;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        mulStart;
  logic        mulSigned;
  logic [31:0] mulA;
  logic [31:0] mulB;
  logic [63:0] mulY;

  logic        opValid1;
  logic [2:0]  op1;
  logic [31:0] opA1;
  logic [31:0] opB1;
  logic        opReady1;
  logic        rdValid1;
  logic [31:0] rdData1;
  logic        busy1;
  logic [31:0] hi1;
  logic [31:0] lo1;
  logic        mulStart1;
  logic        mulSigned1;
  logic [31:0] mulA1;
  logic [31:0] mulB1;
  logic [63:0] mulY1;

  int compared;
  int mismatched;
  int runCnt;
  int runCnt1;

  mdu_hilo #(.WIDTH(32), .MUL_LATENCY(32)) dut (
    .clk(clk), .rst(rst), .op_valid(opValid), .op(op), .op_a(opA), .op_b(opB),
    .op_ready(opReady), .rd_valid(rdValid), .rd_data(rdData), .busy(busy),
    .hi(hi), .lo(lo), .mul_start(mulStart), .mul_is_signed(mulSigned),
    .mul_a(mulA), .mul_b(mulB), .mul_y(mulY)
  );

  mdu_hilo #(.WIDTH(32), .MUL_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .op_valid(opValid1), .op(op1), .op_a(opA1), .op_b(opB1),
    .op_ready(opReady1), .rd_valid(rdValid1), .rd_data(rdData1), .busy(busy1),
    .hi(hi1), .lo(lo1), .mul_start(mulStart1), .mul_is_signed(mulSigned1),
    .mul_a(mulA1), .mul_b(mulB1), .mul_y(mulY1)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 32x32 multiplier, signed or unsigned.
  function automatic logic [63:0] mulModel(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  // Count consecutive cycles of start for each multiplier model.
  always @(posedge clk) begin
    runCnt  <= mulStart  ? runCnt + 1  : 0;
    runCnt1 <= mulStart1 ? runCnt1 + 1 : 0;
  end

  // Product is only valid in the last start cycle; anything else is junk.
  always_comb begin
    mulY  = (mulStart  && runCnt  == 31) ? mulModel(mulSigned,  mulA,  mulB)  : JUNK;
    mulY1 = (mulStart1 && runCnt1 == 0)  ? mulModel(mulSigned1, mulA1, mulB1) : JUNK;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] o,
                               input logic [31:0] a, input logic [31:0] b);
    opValid = v;
    op      = o;
    opA     = a;
    opB     = b;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Wait for the running multiply to finish; reports busy cycles and any cycle
  // in which the launch controls were not held steady.
  task automatic waitIdle(input logic expSigned, output int cycles, output int unstable);
    logic [31:0] a0;
    logic [31:0] b0;
    a0 = mulA;
    b0 = mulB;
    cycles = 0;
    unstable = 0;
    while (busy && cycles < 200) begin
      if (mulStart !== 1'b1 || mulSigned !== expSigned || mulA !== a0 || mulB !== b0)
        unstable++;
      cycles++;
      step(1);
    end
  endtask

  initial begin
    int n;
    int bad;
    int rdPulses;
    compared   = 0;
    mismatched = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
    opValid1 = 1'b0;
    op1  = 3'd0;
    opA1 = 32'h0;
    opB1 = 32'h0;
    step(2);
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_op_ready", opReady, 1'b1);
    checkOutput("reset_hilo", {hi, lo}, 64'h0);
    checkOutput("reset_rd_valid", rdValid, 1'b0);
    checkOutput("reset_mul_start", mulStart, 1'b0);
    checkOutput("reset_mul_ab", {mulA, mulB}, 64'h0);

    $display("[TB] MULTU FFFFFFFF x FFFFFFFF");
    applyStimulus(1'b1, MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step(1);
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
    checkOutput("multu_start", {busy, opReady, mulStart, mulSigned}, 4'b1010);
    waitIdle(1'b0, n, bad);
    checkOutput("multu_busy_cycles", n, 32);
    checkOutput("multu_held", bad, 0);
    checkOutput("multu_hi", hi, 32'hFFFF_FFFE);
    checkOutput("multu_lo", lo, 32'h0000_0001);
    checkOutput("multu_ready_back", opReady, 1'b1);
    applyStimulus(1'b1, MFHI, 32'h0, 32'h0);
    step(1);
    checkOutput("mfhi_pulse", {rdValid, rdData}, {1'b1, 32'hFFFF_FFFE});
    applyStimulus(1'b1, MFLO, 32'h0, 32'h0);
    step(1);
    checkOutput("mflo_pulse", {rdValid, rdData}, {1'b1, 32'h0000_0001});
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
    step(1);
    checkOutput("rd_valid_drop", rdValid, 1'b0);

    $display("[TB] MULT FFFFFFFD x 5");
    applyStimulus(1'b1, MULT, 32'hFFFF_FFFD, 32'h0000_0005);
    step(1);
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
    checkOutput("mult_signed", mulSigned, 1'b1);
    checkOutput("mult_operands", {mulA, mulB}, {32'hFFFF_FFFD, 32'h0000_0005});
    waitIdle(1'b1, n, bad);
    checkOutput("mult_busy_cycles", n, 32);
    checkOutput("mult_held", bad, 0);
    checkOutput("mult_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFF1});

    $display("[TB] MULTU 10000 x 10000 with MFLO held during RUN");
    applyStimulus(1'b1, MULTU, 32'h0001_0000, 32'h0001_0000);
    step(1);
    applyStimulus(1'b1, MFLO, 32'h0, 32'h0);
    n = 0;
    rdPulses = 0;
    while (!opReady && n < 200) begin
      if (rdValid) rdPulses++;
      n++;
      step(1);
    end
    checkOutput("stall_cycles", n, 32);
    checkOutput("stall_no_read", rdPulses, 0);
    step(1);
    checkOutput("interlock_mflo", {rdValid, rdData}, {1'b1, 32'h0000_0000});
    applyStimulus(1'b1, MFHI, 32'h0, 32'h0);
    step(1);
    checkOutput("interlock_mfhi", {rdValid, rdData}, {1'b1, 32'h0000_0001});
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
    step(1);

    $display("[TB] MTHI/MTLO, illegal op, reads");
    applyStimulus(1'b1, MTHI, 32'h1234_5678, 32'h0);
    step(1);
    checkOutput("mthi_hi", hi, 32'h1234_5678);
    applyStimulus(1'b1, MTLO, 32'h9ABC_DEF0, 32'h0);
    step(1);
    checkOutput("mtlo_lo", lo, 32'h9ABC_DEF0);
    checkOutput("mt_no_rd_valid", rdValid, 1'b0);
    applyStimulus(1'b1, 3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step(1);
    checkOutput("illegal_hilo", {hi, lo}, {32'h1234_5678, 32'h9ABC_DEF0});
    checkOutput("illegal_state", {rdValid, busy, opReady, mulStart}, 4'b0010);
    applyStimulus(1'b1, MFHI, 32'h0, 32'h0);
    step(1);
    checkOutput("mt_mfhi", {rdValid, rdData}, {1'b1, 32'h1234_5678});
    applyStimulus(1'b1, MFLO, 32'h0, 32'h0);
    step(1);
    checkOutput("mt_mflo", {rdValid, rdData}, {1'b1, 32'h9ABC_DEF0});
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
    step(1);

    $display("[TB] reset during RUN");
    applyStimulus(1'b1, MULTU, 32'd3, 32'd4);
    step(1);
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
    step(9);
    checkOutput("pre_reset_busy", busy, 1'b1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checkOutput("rst_run_ctrl", {busy, mulStart, opReady}, 3'b001);
    checkOutput("rst_run_hilo", {hi, lo}, 64'h0);
    applyStimulus(1'b1, MULTU, 32'd7, 32'd6);
    step(1);
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
    waitIdle(1'b0, n, bad);
    checkOutput("after_rst_cycles", n, 32);
    checkOutput("after_rst_hilo", {hi, lo}, {32'd0, 32'd42});

    $display("[TB] latency 1 variant");
    opValid1 = 1'b1;
    op1  = MULTU;
    opA1 = 32'h8000_0000;
    opB1 = 32'h0000_0002;
    step(1);
    opValid1 = 1'b0;
    checkOutput("lat1_run", {busy1, opReady1, mulStart1}, 3'b101);
    checkOutput("lat1_hilo_pending", {hi1, lo1}, 64'h0);
    step(1);
    checkOutput("lat1_hilo", {hi1, lo1}, {32'h0000_0001, 32'h0000_0000});
    checkOutput("lat1_ready", {busy1, opReady1, mulStart1}, 3'b010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Multiply/divide-unit front end that sits between the CPU decode/execute stage and the sequential `mul` multiplier. It accepts MULT/MULTU requests and drives the multiplier's operand, `start` and `is_signed` inputs. After a fixed latency it captures the 64-bit product into the architectural HI/LO registers. It also services MFHI/MFLO/MTHI/MTLO, and stalls the pipeline through `op_ready` while a multiply is in flight.

## Interface
- `WIDTH`, 32, operand and HI/LO width; the product is 2*WIDTH.
- `MUL_LATENCY`, 32, number of RUN cycles (mul_start high) before `mul_y` is valid; must be ≥1.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `op_valid`  in  1  request present.
- `op`  in  3  0=MULT, 1=MULTU, 2=MFHI, 3=MFLO, 4=MTHI, 5=MTLO, 6/7 illegal.
- `op_a`  in  WIDTH  multiplicand, or write data for MTHI/MTLO.
- `op_b`  in  WIDTH  multiplier operand.
- `op_ready`  out  1  request accepted on an edge where `op_valid & op_ready`.
- `rd_valid`  out  1  one-cycle pulse; `rd_data` is valid.
- `rd_data`  out  WIDTH  MFHI/MFLO result.
- `busy`  out  1  multiply in flight.
- `hi`, `lo`  out  WIDTH each  architectural HI/LO contents.
- `mul_start`  out  1  to multiplier `start`.
- `mul_is_signed`  out  1  to multiplier `is_signed`.
- `mul_a`, `mul_b`  out  WIDTH each  to multiplier `a`, `b`.
- `mul_y`  in  2*WIDTH  multiplier product `y`.

## Operation
- FSM states: IDLE and RUN.
  - `op_ready = (state==IDLE)`.
  - `busy = (state==RUN)`.
- IDLE, accepted MULT/MULTU:
  - Register `op_a`→`mul_a` and `op_b`→`mul_b`.
  - Set `mul_is_signed` (1 for MULT, 0 for MULTU).
  - Set `mul_start`=1, clear the counter, go to RUN.
- RUN:
  - `mul_start`, `mul_a`, `mul_b` and `mul_is_signed` are held stable.
  - The counter increments each cycle; counter width is clog2(MUL_LATENCY+1).
  - On the edge that ends the MUL_LATENCY-th RUN cycle: `{hi,lo} <= mul_y`, `mul_start <= 0`, go to IDLE.
- IDLE, accepted MFHI/MFLO: on the next edge, `rd_data <= hi` (or `lo`) and `rd_valid <= 1` for exactly one cycle.
- IDLE, accepted MTHI/MTLO: `hi` (or `lo`) `<= op_a` at the acceptance edge. `rd_valid` is not asserted.
- Illegal ops 6/7: accepted as a no-op. No register change, no `rd_valid`.
- Requests presented during RUN are not accepted. The requester holds `op_valid`, `op` and operands until accepted. This is the HI/LO interlock: a read after MULT always returns the new product.
- Product arithmetic is entirely in the multiplier. This block does no sign handling beyond driving `mul_is_signed`.
- Reset values (applied at the edge where `rst`=1, from any state, including mid-RUN):
  - State IDLE, counter 0.
  - `hi`=`lo`=0, `rd_valid`=0, `rd_data`=0.
  - `mul_start`=0, `mul_is_signed`=0, `mul_a`=`mul_b`=0.
  - Hence `busy`=0 and `op_ready`=1 in the cycle after reset.
- Reset mid-RUN discards the in-flight product. The multiplier sees `start` fall and restarts cleanly on the next MULT.

## Timing
- All outputs are registered or decoded directly from the state register. There is no combinational path from `op_*` to any output.
- MULT/MULTU accepted at edge T:
  - `mul_start` is high in cycles T..T+MUL_LATENCY-1.
  - `hi`/`lo` update at edge T+MUL_LATENCY.
  - `op_ready` is high again in the cycle after that edge.
  - The earliest next acceptance is edge T+MUL_LATENCY+1.
- MFHI/MFLO accepted at edge T: `rd_valid`/`rd_data` are visible in the cycle after edge T. Back-to-back reads produce back-to-back pulses.
- MTHI at edge T followed by MFHI at edge T+1 returns the MTHI value.
- Contract on `mul_y`: it must hold the correct product during the MUL_LATENCY-th cycle of continuous `mul_start`. The bench multiplier model implements exactly this.

## Test plan
- MULTU, `op_a`=`op_b`=0xFFFFFFFF, then MFHI and MFLO → `busy` high for 32 cycles; `hi`=0xFFFFFFFE, `lo`=0x00000001; `rd_data` 0xFFFFFFFE then 0x00000001, each with a one-cycle `rd_valid`.
- MULT, 0xFFFFFFFD × 0x00000005 → `mul_is_signed`=1 throughout RUN; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
- MULTU 0x00010000 × 0x00010000, with MFLO held valid the cycle after → `op_ready`=0 for 32 cycles; MFLO accepted at T+33 returns 0x00000000; a following MFHI returns 0x00000001.
- MTHI 0x12345678 and MTLO 0x9ABCDEF0 back-to-back, then MFHI, MFLO → 0x12345678, 0x9ABCDEF0; an illegal op 7 in between changes nothing and produces no `rd_valid`.
- MULTU 3×4 with `rst` pulsed in RUN cycle 10 → next cycle `busy`=0, `mul_start`=0, `hi`=`lo`=0, `op_ready`=1; a subsequent MULTU 7×6 gives `lo`=42, `hi`=0.
- Parameter variant MUL_LATENCY=1: MULTU 0x80000000×2 → `hi`=1, `lo`=0 at edge T+1; `op_ready` returns at T+2.
